// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package wb_pkg;
  localparam int REG_AW   = 5;
  localparam int REG_DW   = 32;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_entry_t;

  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;
endpackage

// File: rtl/wb_arbiter_if.sv
// Producer handshakes, register-file write port and pending mask of the write-back arbiter.
interface wb_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          A_valid_i;
  logic          A_ready_o;
  logic [AW-1:0] A_addr_i;
  logic [DW-1:0] A_data_i;
  logic          B_valid_i;
  logic          B_ready_o;
  logic [AW-1:0] B_addr_i;
  logic [DW-1:0] B_data_i;
  logic          RegWrite_o;
  logic [AW-1:0] RDaddr_o;
  logic [DW-1:0] RDdata_o;
  logic [2**AW-1:0] pending_o;

  modport slave (
    input  A_valid_i, A_addr_i, A_data_i, B_valid_i, B_addr_i, B_data_i,
    output A_ready_o, B_ready_o, RegWrite_o, RDaddr_o, RDdata_o, pending_o
  );

  modport master (
    output A_valid_i, A_addr_i, A_data_i, B_valid_i, B_addr_i, B_data_i,
    input  A_ready_o, B_ready_o, RegWrite_o, RDaddr_o, RDdata_o, pending_o
  );
endinterface

// File: rtl/wb_fifo.sv
// Small per-source FIFO of write-back entries; exposes every slot and its valid bit
// so the parent can build the pending-register mask.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH-1:0]      entry_valid,
  output wb_entry_t [DEPTH-1:0] entries
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t       mem_reg [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW:0]     count_reg;

  // Storage carries no reset: stale slots are masked by entry_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign full  = (count_reg == (PW+1)'(DEPTH));
  assign empty = (count_reg == '0);

  // A slot is live when its distance from the read pointer is below the count.
  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [PW-1:0] offs;
    assign offs            = PW'(gi) - rd_ptr_reg;
    assign entry_valid[gi] = ({1'b0, offs} < count_reg);
    assign entries[gi]     = mem_reg[gi];
  end
endmodule

// File: rtl/wb_arbiter.sv
// Merges two write-back producers into the single register-file write port with
// round-robin arbitration on contention and a pending-register mask for hazards.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic         clk_i,
  input  logic         rst_i,
  wb_arbiter_if.slave  bus
);
  wb_entry_t             a_head, b_head, win_entry;
  logic                  a_full, a_empty, b_full, b_empty;
  logic [DEPTH-1:0]      a_vld, b_vld;
  wb_entry_t [DEPTH-1:0] a_entries, b_entries;
  logic                  a_push, b_push;
  logic                  grant_a, grant_b;
  src_e                  rr_reg, rr_next;
  logic                  regwrite_reg;
  logic [AW-1:0]         rdaddr_reg;
  logic [DW-1:0]         rddata_reg;
  logic [2**AW-1:0]      pending_next;

  // Readiness depends only on the registered count, so a full FIFO refuses even while popping.
  assign a_push = bus.A_valid_i & ~a_full;
  assign b_push = bus.B_valid_i & ~b_full;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk(clk_i), .rst(rst_i), .push(a_push),
    .push_entry('{addr: bus.A_addr_i, data: bus.A_data_i}),
    .pop(grant_a), .head(a_head), .full(a_full), .empty(a_empty),
    .entry_valid(a_vld), .entries(a_entries)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk(clk_i), .rst(rst_i), .push(b_push),
    .push_entry('{addr: bus.B_addr_i, data: bus.B_data_i}),
    .pop(grant_b), .head(b_head), .full(b_full), .empty(b_empty),
    .entry_valid(b_vld), .entries(b_entries)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_reg <= SRC_A;
    else       rr_reg <= rr_next;
  end

  // The rr pointer names the favoured source and only moves on contested grants.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    rr_next = rr_reg;
    if (!a_empty && !b_empty) begin
      if (rr_reg == SRC_A) grant_a = 1'b1;
      else                 grant_b = 1'b1;
      rr_next = (rr_reg == SRC_A) ? SRC_B : SRC_A;
    end else if (!a_empty) begin
      grant_a = 1'b1;
    end else if (!b_empty) begin
      grant_b = 1'b1;
    end
  end

  assign win_entry = grant_b ? b_head : a_head;

  // r0 entries still pop and update addr/data, but never raise the strobe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      regwrite_reg <= 1'b0;
      rdaddr_reg   <= '0;
      rddata_reg   <= '0;
    end else begin
      regwrite_reg <= (grant_a | grant_b) && (win_entry.addr != '0);
      if (grant_a | grant_b) begin
        rdaddr_reg <= win_entry.addr;
        rddata_reg <= win_entry.data;
      end
    end
  end

  always_comb begin
    pending_next = '0;
    for (int d = 0; d < DEPTH; d++) begin
      if (a_vld[d]) pending_next[a_entries[d].addr] = 1'b1;
      if (b_vld[d]) pending_next[b_entries[d].addr] = 1'b1;
    end
    if (regwrite_reg) pending_next[rdaddr_reg] = 1'b1;
    pending_next[0] = 1'b0;
  end

  assign bus.A_ready_o  = ~a_full;
  assign bus.B_ready_o  = ~b_full;
  assign bus.RegWrite_o = regwrite_reg;
  assign bus.RDaddr_o   = rdaddr_reg;
  assign bus.RDdata_o   = rddata_reg;
  assign bus.pending_o  = pending_next;
endmodule
